clk_period_meter: RTL
=====================

# clk_period_meter

Measures an incoming divided clock. The block samples a slow clock-like signal, such as a clock-divider output, in the fast system clock domain. For each full cycle of that signal it reports the period and the high time, both as counts of `i_clk` cycles, and it flags loss of the signal. It sits downstream of the clock-divider blocks as the consuming end of a divided clock: a self-check monitor and a bring-up measurement aid.

## Interface
- `P_CNT_WIDTH`, default 16: width of all counters and measurement outputs.
- `P_SYNC_STAGES`, default 2: flops in the input synchronizer, minimum 2.
- `P_TIMEOUT`, default 1000: `i_clk` cycles with no edge on the input before loss is declared. Must be less than 2^`P_CNT_WIDTH`.
- `i_clk`, input, 1: system clock. Single clock domain.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_clk_div`, input, 1: measured signal, asynchronous to `i_clk`.
- `i_en`, input, 1: measurement enable, level.
- `o_period`, output, `P_CNT_WIDTH`: last completed rise-to-rise period, in `i_clk` cycles.
- `o_high`, output, `P_CNT_WIDTH`: last completed rise-to-fall high time, in `i_clk` cycles.
- `o_valid`, output, 1: one-cycle pulse when `o_period` and `o_high` update.
- `o_lost`, output, 1: level, input declared lost.

## Operation
- **Synchronizer and edge detect.** `i_clk_div` passes through `P_SYNC_STAGES` flops, then a 1-flop edge detector. A rise or fall is detected when the synced value differs from the delayed value.
- **Period counter `r_per`.** Loaded with 1 on a rise-detect cycle. Incremented on every other cycle. Saturates at 2^W−1 and does not wrap.
- **Idle counter.** Cleared on any detected edge. Otherwise increments, saturating at 2^W−1.
- **FSM states:** ST_IDLE, ST_HIGH, ST_LOW, ST_LOST.
  - ST_IDLE: entered from reset, or whenever `i_en`=0 (which overrides all other transitions). A rise goes to ST_HIGH. No capture happens here; the first partial period is always discarded.
  - ST_HIGH: a fall captures `r_high` = `r_per` and goes to ST_LOW.
  - ST_LOW: a rise loads `o_period` from `r_per` and `o_high` from `r_high`, pulses `o_valid`, and returns to ST_HIGH.
  - ST_HIGH or ST_LOW: if the idle counter reaches ≥ `P_TIMEOUT`, go to ST_LOST and set `o_lost`=1.
  - ST_LOST: a rise clears `o_lost` and goes to ST_HIGH. No `o_valid` until a further full period has completed.
- **Retained values.** `o_period` and `o_high` hold their last values in ST_IDLE and ST_LOST.
- **Disable.** `i_en` falling clears `o_lost`, `r_per` and the idle counter on the next edge of `i_clk`.
- **Edge cases.**
  - A rise and the timeout threshold in the same cycle: the rise wins, there is no loss, and the capture proceeds.
  - A glitch that produces a rise and a fall on consecutive cycles is measured as is; there is no filtering.
- **Reset values.** `o_period`=0, `o_high`=0, `o_valid`=0, `o_lost`=0, all counters 0, state ST_IDLE. Reset applies immediately, including mid-measurement.

## Timing
- **Input to detect.** An edge on `i_clk_div` is detected `P_SYNC_STAGES`+1 cycles after it is sampled.
- **Detect to output.** `o_valid`, `o_period` and `o_high` update on the `i_clk` edge that ends the rise-detect cycle, so they are visible the following cycle.
- **First result.** The first `o_valid` arrives at the second synced rise after enable. That is 2 input periods plus `P_SYNC_STAGES`+2 cycles, worst case.
- **Divider mapping.** An ideal divide-by-2N input gives `o_period`=2N and `o_high`=N. For N=1 that is `o_period`=2, `o_high`=1, with `o_valid` every 2 cycles.
- **Loss timing.** `o_lost` rises `P_TIMEOUT`+1 cycles after the last detected edge.

## Configuration
- Macro: `CLK_PERIOD_METER_DUTY_EN`.
- Defined: the `r_high` capture is built and `o_high` reports the high time.
- Undefined: the `r_high` logic is removed and `o_high` is tied to 0. The fall edge still moves the FSM from ST_HIGH to ST_LOW. Period measurement and loss detection are unchanged.

## Structure
- **Package `clk_meter_pkg`:**
  - FSM state typedef: ST_IDLE, ST_HIGH, ST_LOW, ST_LOST.
  - Default width constant, 16.
  - Default timeout constant, 1000.
- **Sub-module `edge_sync`:** `P_SYNC_STAGES` synchronizer plus edge detect. Outputs: synced level, rise pulse, fall pulse. Reset value is all 0.
- **Top:** the FSM, the counters and the output registers.

## Test plan
- **Divide-by-10 input** (5 high, 5 low), enabled: from the second rise, `o_valid` pulses every 10 cycles with `o_period`=10 and `o_high`=5.
- **Divide-by-2 input:** `o_period`=2, `o_high`=1, `o_valid` every 2 cycles.
- **Loss and recovery,** with `P_TIMEOUT`=64: a divide-by-10 input is held high.
  - `o_lost`=1 65 cycles after the last rise, and `o_period` holds 10.
  - On restart, the first rise clears `o_lost`, and `o_valid` returns one period later.
- **Disable mid-high:** drop `i_en` for 3 cycles. Result: no `o_valid`, state ST_IDLE, outputs retained. After re-enable, 2 rises are needed before the next `o_valid`.
- **Saturation,** `P_CNT_WIDTH`=4 with a 20-cycle input period: `o_period`=15.
- **Reset mid-measurement:** assert `i_rst_n`=0 in ST_LOW. All outputs read 0 asynchronously before the next `i_clk` edge. Measurement restarts after release.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared types and defaults for clk_period_meter
package clk_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_LOST = 2'd3
   } meter_state_e;

   localparam int CNT_WIDTH_DEF = 16;
   localparam int TIMEOUT_DEF   = 1000;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchronizer followed by a one-flop edge detector
module edge_sync #(
   parameter int P_SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [P_SYNC_STAGES-1:0] sync_q;
   logic [P_SYNC_STAGES-1:0] sync_d;
   logic                     dly_q;
   logic                     dly_d;

   always_comb begin
      sync_d = {sync_q[P_SYNC_STAGES-2:0], i_d};
      dly_d  = sync_q[P_SYNC_STAGES-1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign o_level = sync_q[P_SYNC_STAGES-1];
   assign o_rise  = o_level & ~dly_q;
   assign o_fall  = ~o_level & dly_q;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period / high-time meter and loss monitor for a divided clock
// Optional high-time capture is built when CLK_PERIOD_METER_DUTY_EN is defined.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int P_CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int P_SYNC_STAGES = 2,
   parameter int P_TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clk_div,
   input  logic                   i_en,
   output logic [P_CNT_WIDTH-1:0] o_period,
   output logic [P_CNT_WIDTH-1:0] o_high,
   output logic                   o_valid,
   output logic                   o_lost
);

   localparam logic [P_CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [P_CNT_WIDTH-1:0] TIMEOUT_C = P_TIMEOUT[P_CNT_WIDTH-1:0];

   logic rise;
   logic fall;
   logic level_unused;

   meter_state_e           state_q, state_d;
   logic [P_CNT_WIDTH-1:0] per_q, per_d;
   logic [P_CNT_WIDTH-1:0] idle_q, idle_d;
   logic [P_CNT_WIDTH-1:0] period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   lost_q, lost_d;
   logic                   timeout;

   edge_sync #(
      .P_SYNC_STAGES(P_SYNC_STAGES)
   ) u_edge_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_clk_div),
      .o_level (level_unused),
      .o_rise  (rise),
      .o_fall  (fall)
   );

   // Counters: disable clears both, detected edges restart them, both saturate.
   always_comb begin
      per_d  = per_q;
      idle_d = idle_q;
      if (!i_en) begin
         per_d  = '0;
         idle_d = '0;
      end else begin
         if (rise)
            per_d = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
         else if (per_q != CNT_MAX)
            per_d = per_q + 1'b1;

         if (rise || fall)
            idle_d = '0;
         else if (idle_q != CNT_MAX)
            idle_d = idle_q + 1'b1;
      end
   end

   // Judged on the next idle value so o_lost appears P_TIMEOUT+1 cycles after the last edge.
   assign timeout = (idle_d >= TIMEOUT_C);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!i_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
               if (fall)         state_d = ST_LOW;
               else if (timeout) state_d = ST_LOST;
            end
            ST_LOW: begin
               if (rise)         state_d = ST_HIGH;
               else if (timeout) state_d = ST_LOST;
            end
            ST_LOST: if (rise) state_d = ST_HIGH;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      valid_d  = i_en && (state_q == ST_LOW) && rise;
      period_d = valid_d ? per_q : period_q;
      lost_d   = (state_d == ST_LOST);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         per_q    <= '0;
         idle_q   <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         per_q    <= per_d;
         idle_q   <= idle_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         lost_q   <= lost_d;
      end
   end

`ifdef CLK_PERIOD_METER_DUTY_EN
   logic [P_CNT_WIDTH-1:0] r_high_q, r_high_d;
   logic [P_CNT_WIDTH-1:0] high_q, high_d;

   always_comb begin
      r_high_d = (i_en && (state_q == ST_HIGH) && fall) ? per_q : r_high_q;
      high_d   = valid_d ? r_high_q : high_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_high_q <= '0;
         high_q   <= '0;
      end else begin
         r_high_q <= r_high_d;
         high_q   <= high_d;
      end
   end

   assign o_high = high_q;
`else
   assign o_high = '0;
`endif

   assign o_period = period_q;
   assign o_valid  = valid_q;
   assign o_lost   = lost_q;

endmodule
